// File: rtl/fifo_prog_sync_pkg.sv
// Shared types and sizing helpers for the programmable synchronous FIFO.
package fifo_prog_sync_pkg;

    typedef enum bit {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    localparam int FIFO_DEF_WIDTH = 16;
    localparam int FIFO_DEF_DEPTH = 8;

    // Occupancy needs one extra bit so that "full" (count == depth) is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_dp_mem.sv
// Purpose: FIFO storage array, one write port and one read port.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller gates we.
module fifo_dp_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog_sync.sv
// Purpose: single-clock FIFO with programmable almost flags, flush and sticky errors.
// Latency: standard mode data 1 cycle after rd_en; FWFT mode head word visible 1 cycle after its write.
// Backpressure: writes rejected at full unless a read is accepted the same cycle (overflow pulse).
module fifo_prog_sync
    import fifo_prog_sync_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int FWFT       = 0,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = fifo_cnt_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    input  logic                  clr_sticky,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ovf_sticky,
    output logic                  unf_sticky
);

    localparam fifo_mode_e       MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  wr_rej;
    logic                  rd_rej;
    logic                  mem_we;
    logic [FIFO_WIDTH-1:0] mem_rd_dat;

    assign full        = (count == DEPTH_CNT);
    assign empty       = (count == '0);
    assign almostfull  = (count >= af_thresh);
    assign almostempty = (count <= ae_thresh);

    // A read at full frees a slot in the same cycle, so the write is let through.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);
    assign wr_rej = wr_en && !wr_acc;
    assign rd_rej = rd_en && !rd_acc;
    assign mem_we = wr_acc && !flush && !rst;

    fifo_dp_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            wr_ack    <= wr_acc;
            overflow  <= wr_rej;
            underflow <= rd_rej;
            // A new error event outranks a simultaneous clear.
            if (wr_rej) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
            if (rd_rej) begin
                unf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                unf_sticky <= 1'b0;
            end
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word is shown directly; zero while empty so stale entries never leak out.
            assign data_out = empty ? '0 : mem_rd_dat;
            assign valid    = !empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    if (rd_acc) begin
                        dout_q <= mem_rd_dat;
                    end
                    valid_q <= rd_acc;
                end
            end

            assign data_out = dout_q;
            assign valid    = valid_q;
        end
    endgenerate

    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);
    a_no_unf:    assert property (@(posedge clk) disable iff (rst) !(rd_acc && count == '0));
    a_flags_exc: assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule

// File: tb/tb_fifo_prog_sync.sv
// Drives a standard-mode and a FWFT-mode FIFO with identical stimulus and
// compares both against a queue-based reference of the FIFO rules.
module tb_fifo_prog_sync;
    import fifo_prog_sync_pkg::*;

    localparam int W  = FIFO_DEF_WIDTH;
    localparam int D  = FIFO_DEF_DEPTH;
    localparam int CW = fifo_cnt_w(D);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  data_in;
    logic          wr_en;
    logic          rd_en;
    logic          flush;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic          clr_sticky;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_valid, f_valid;
    logic [CW-1:0] s_count, f_count;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic          s_ack, f_ack, s_ovf, f_ovf, s_unf, f_unf;
    logic          s_osti, f_osti, s_usti, f_usti;

    fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .clr_sticky(clr_sticky), .data_out(s_dout), .valid(s_valid),
        .count(s_count), .full(s_full), .empty(s_empty), .almostfull(s_af),
        .almostempty(s_ae), .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_unf),
        .ovf_sticky(s_osti), .unf_sticky(s_usti)
    );

    fifo_prog_sync #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .clr_sticky(clr_sticky), .data_out(f_dout), .valid(f_valid),
        .count(f_count), .full(f_full), .empty(f_empty), .almostfull(f_af),
        .almostempty(f_ae), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
        .ovf_sticky(f_osti), .unf_sticky(f_usti)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: stored words in order plus the registered status bits.
    logic [W-1:0] q[$];
    logic         m_ack, m_ovf, m_unf, m_osti, m_usti, m_valid;
    logic [W-1:0] m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("std.count",  32'(s_count), 32'(sz));
        chk("fwft.count", 32'(f_count), 32'(sz));
        chk("std.full",   32'(s_full),  32'(sz == D));
        chk("fwft.full",  32'(f_full),  32'(sz == D));
        chk("std.empty",  32'(s_empty), 32'(sz == 0));
        chk("fwft.empty", 32'(f_empty), 32'(sz == 0));
        chk("std.af",     32'(s_af),    32'(sz >= int'(af_thresh)));
        chk("fwft.af",    32'(f_af),    32'(sz >= int'(af_thresh)));
        chk("std.ae",     32'(s_ae),    32'(sz <= int'(ae_thresh)));
        chk("fwft.ae",    32'(f_ae),    32'(sz <= int'(ae_thresh)));
        chk("std.wr_ack", 32'(s_ack),   32'(m_ack));
        chk("fwft.wr_ack",32'(f_ack),   32'(m_ack));
        chk("std.ovf",    32'(s_ovf),   32'(m_ovf));
        chk("fwft.ovf",   32'(f_ovf),   32'(m_ovf));
        chk("std.unf",    32'(s_unf),   32'(m_unf));
        chk("fwft.unf",   32'(f_unf),   32'(m_unf));
        chk("std.ovf_sticky",  32'(s_osti), 32'(m_osti));
        chk("fwft.ovf_sticky", 32'(f_osti), 32'(m_osti));
        chk("std.unf_sticky",  32'(s_usti), 32'(m_usti));
        chk("fwft.unf_sticky", 32'(f_usti), 32'(m_usti));
        chk("std.valid",  32'(s_valid), 32'(m_valid));
        chk("std.data",   32'(s_dout),  32'(m_dout));
        chk("fwft.valid", 32'(f_valid), 32'(sz != 0));
        if (sz != 0) begin
            chk("fwft.data", 32'(f_dout), 32'(q[0]));
        end
    endtask

    // One clock cycle: apply inputs, let the edge happen, advance the reference, compare.
    task automatic step(input logic r, input logic w, input logic rd, input logic fl,
                        input logic clr, input logic [W-1:0] d);
        int  sz;
        logic rd_ok, wr_ok;
        rst = r; wr_en = w; rd_en = rd; flush = fl; clr_sticky = clr; data_in = d;
        @(posedge clk);
        sz = q.size();
        if (r) begin
            q.delete();
            {m_ack, m_ovf, m_unf, m_osti, m_usti, m_valid} = '0;
            m_dout = '0;
        end else if (fl) begin
            q.delete();
            {m_ack, m_ovf, m_unf, m_valid} = '0;
        end else begin
            rd_ok = rd && (sz > 0);
            wr_ok = w && ((sz < D) || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_ack = wr_ok;
            m_ovf = w && !wr_ok;
            m_unf = rd && !rd_ok;
            if (m_ovf) m_osti = 1'b1; else if (clr) m_osti = 1'b0;
            if (m_unf) m_usti = 1'b1; else if (clr) m_usti = 1'b0;
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_sticky = 1'b0;
        data_in = '0; af_thresh = CW'(6); ae_thresh = CW'(2);
        m_dout = '0;
        {m_ack, m_ovf, m_unf, m_osti, m_usti, m_valid} = '0;

        step(1, 0, 0, 0, 0, '0);
        step(1, 1, 1, 0, 0, 16'hFFFF);

        // Fill, then overflow on the ninth write; then one idle cycle.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 0, W'(i));
        step(0, 1, 0, 0, 0, 16'h0009);
        step(0, 0, 0, 0, 0, '0);

        // Simultaneous read/write at full, then drain; last word is 0x00AA.
        step(0, 1, 1, 0, 0, 16'h00AA);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, '0);

        // Simultaneous read/write at empty, then read the word back.
        step(0, 1, 1, 0, 0, 16'h1234);
        step(0, 0, 1, 0, 0, '0);

        // Threshold sweep 0..8 entries, then raise af_thresh beyond depth.
        af_thresh = CW'(6); ae_thresh = CW'(2);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, W'(16'h0100 + i));
        af_thresh = CW'(9);
        step(0, 0, 0, 0, 0, '0);
        af_thresh = '0; ae_thresh = '0;
        step(0, 0, 0, 0, 0, '0);
        af_thresh = CW'(6); ae_thresh = CW'(2);

        // Down to 5 entries, flush with a colliding write, then clear stickies.
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, '0);
        step(0, 1, 0, 1, 0, 16'hDEAD);
        step(0, 0, 0, 0, 1, '0);

        // FWFT head appears without a read; reading it empties the FIFO.
        step(0, 1, 0, 0, 0, 16'hA5A5);
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 1, 0, 0, '0);

        // Clear together with a fresh overflow keeps the sticky bit set.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, W'(16'h0200 + i));
        step(0, 1, 0, 0, 1, 16'h0BAD);
        step(0, 0, 0, 0, 0, '0);

        // Reset with three entries stored.
        step(0, 0, 0, 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, W'(16'h0300 + i));
        step(1, 0, 0, 0, 0, '0);

        // Randomised traffic with occasional flush/clear/reset and threshold changes.
        for (int i = 0; i < 3000; i++) begin
            logic r, w, rd, fl, clr;
            if ($urandom_range(0, 19) == 0) begin
                af_thresh = CW'($urandom_range(0, (1 << CW) - 1));
                ae_thresh = CW'($urandom_range(0, (1 << CW) - 1));
            end
            r   = ($urandom_range(0, 299) == 0);
            fl  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 29) == 0);
            w   = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 65 : 35));
            rd  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 65));
            step(r, w, rd, fl, clr, W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_prog_sync.md
Name: fifo_prog_sync

Overview:
- Parametrised successor of the team's synchronous FIFO, with generic width/depth and a compile-time standard or first-word-fall-through (FWFT) read mode.
- Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy output, a synchronous flush, and sticky error flags.
- Write-through at full when a read is accepted in the same cycle.
- Sits between producer/consumer stages of one clock domain; the UVM FIFO environment is reused with extended sequences.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- Derived localparams: PTR_W = $clog2(FIFO_DEPTH), CNT_W = PTR_W+1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request; in FWFT mode it acts as the pop/acknowledge.
- flush  in  1  synchronous clear of contents.
- af_thresh  in  CNT_W  almost-full threshold.
- ae_thresh  in  CNT_W  almost-empty threshold.
- clr_sticky  in  1  clears the sticky error flags.
- data_out  out  FIFO_WIDTH  read data.
- valid  out  1  data_out holds valid read data.
- count  out  CNT_W  current occupancy.
- full, empty, almostfull, almostempty  out  1 each  status flags.
- wr_ack  out  1  previous-cycle write was accepted.
- overflow  out  1  previous-cycle write was rejected.
- underflow  out  1  previous-cycle read was rejected.
- ovf_sticky, unf_sticky  out  1 each  latched error flags.

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0; valid, wr_ack, overflow, underflow, ovf_sticky, unf_sticky = 0.
  - rst has priority over every other input.
- Read acceptance: rd_acc = rd_en && !empty.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc).
  - At full, a simultaneous read frees a slot, so both operations are accepted.
  - At empty, a simultaneous read is rejected (underflow) and the write is accepted.
- Occupancy and pointers:
  - count_next = count + wr_acc - rd_acc.
  - Pointers increment by 1 on acceptance and wrap naturally modulo FIFO_DEPTH.
  - mem[wr_ptr] is written on wr_acc.
- Status flags:
  - wr_ack, overflow and underflow are registered, 1-cycle pulses following the request cycle.
  - wr_ack = wr_acc; overflow = wr_en && !wr_acc; underflow = rd_en && !rd_acc.
- Sticky flags:
  - ovf_sticky is set by any overflow event and cleared by clr_sticky; set wins when both occur in the same cycle.
  - unf_sticky behaves the same for underflow events.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr], valid = 1 in the next cycle only.
  - data_out holds its value otherwise; latency is 1 cycle from rd_en.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - A write into an empty FIFO appears on data_out the cycle after the write edge.
  - rd_acc advances to the next word.
- Combinational flags from the count register:
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - almostfull = (count >= af_thresh); almostempty = (count <= ae_thresh).
  - af_thresh > FIFO_DEPTH means almostfull is never asserted; af_thresh = 0 means it is always asserted.
  - ae_thresh = 0 makes almostempty equal to empty.
  - Thresholds may change at any time; the flags follow in the same cycle.
- Flush (flush=1, rst=0):
  - Pointers and count = 0; wr_en and rd_en are ignored that cycle.
  - wr_ack, overflow, underflow, valid = 0.
  - Sticky flags and stored memory contents are unchanged; data_out holds in standard mode.
- Count never exceeds FIFO_DEPTH and never underflows below 0. Assertions cover both, plus full&&empty never true together.

Decomposition:
- shared_pkg additions:
  - typedef enum bit {FIFO_STD, FIFO_FWFT} fifo_mode_e.
  - Function fifo_cnt_w(depth) returning $clog2(depth)+1.
  - Default width/depth constants for the bench.
- One sub-module: fifo_dp_mem, FIFO_DEPTH x FIFO_WIDTH with synchronous write and asynchronous read, no reset on the array.
- Top level holds the pointers, count, flags and read-mode logic.

Test Plan (WIDTH=16, DEPTH=8, FWFT=0 unless stated):
- Fill and overflow:
  - Stimulus: 8 writes of 0x0001..0x0008, then a 9th write of 0x0009.
  - Response: wr_ack on each of the first 8, count=8, full=1; the 9th gives overflow=1 for 1 cycle, ovf_sticky=1, count stays 8.
- Read/write at full:
  - Stimulus: from full, wr_en=rd_en=1 with 0x00AA.
  - Response: both accepted, count=8, overflow=0, next cycle data_out=0x0001 with valid=1; the 8th subsequent read returns 0x00AA.
- Read/write at empty:
  - Stimulus: from empty, wr_en=rd_en=1 with 0x1234.
  - Response: underflow=1, unf_sticky=1, count=1, wr_ack=1; the next read returns 0x1234.
- Threshold sweep:
  - Stimulus: af_thresh=6, ae_thresh=2; write 0 to 8 entries, then change af_thresh to 9.
  - Response: almostempty for count 0-2, almostfull for count 6-8; after af_thresh=9, almostfull=0 at count=8.
- Flush mid-stream:
  - Stimulus: count=5, then flush=1 with wr_en=1 the same cycle.
  - Response: count=0, empty=1, wr_ack=0, write dropped, sticky flags unchanged.
  - Follow-up: clr_sticky=1 together with a new overflow leaves ovf_sticky=1.
- FWFT=1 and reset:
  - Stimulus: write 0xA5A5 to an empty FIFO.
  - Response: next cycle valid=1, data_out=0xA5A5 with no rd_en; rd_en=1 gives empty=1, valid=0.
  - Stimulus: rst=1 with count=3.
  - Response: all outputs go to their reset values at that edge.
